// File: rtl/n64_bank_dispatcher.sv
// n64_bank_dispatcher
// Routes one decoded N64 bus transaction to the bank target that owns it and
// returns that target's completion (read data / error) to the initiator.
// Only one transaction is in flight at a time; requests while busy are dropped.
// Optional bank-side ack timeout: define N64_BANK_DISPATCHER_TIMEOUT_EN.
module n64_bank_dispatcher #(
    parameter int NUM_BANKS      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_request,
    input  logic                    i_write,
    input  logic [3:0]              i_bank,
    input  logic [25:0]             i_address,
    input  logic [15:0]             i_wdata,
    output logic                    o_busy,
    output logic                    o_ack,
    output logic [15:0]             o_rdata,
    output logic                    o_error,
    output logic [NUM_BANKS-1:0]    o_bank_request,
    output logic                    o_bank_write,
    output logic [25:0]             o_bank_address,
    output logic [15:0]             o_bank_wdata,
    input  logic [NUM_BANKS-1:0]    i_bank_ack,
    input  logic [16*NUM_BANKS-1:0] i_bank_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [3:0]  bank_q, bank_d;
    logic [25:0] address_q, address_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic [15:0] bank_rdata [NUM_BANKS];
    logic        sel_ack;
    logic [15:0] sel_rdata;
    logic        bank_valid;
    logic        timeout_hit;

    // Split the flat read-data bus into per-bank words and decode the one-hot request.
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            assign bank_rdata[gi]     = i_bank_rdata[16*gi +: 16];
            assign o_bank_request[gi] = (state_q == ST_WAIT) && (bank_q == 4'(gi));
        end
    endgenerate

    assign bank_valid = ({28'd0, i_bank} < 32'(NUM_BANKS));

    // Pick out the ack and read data of the latched bank; other banks are ignored.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = 16'h0000;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (bank_q == 4'(k)) begin
                sel_ack   = i_bank_ack[k];
                sel_rdata = bank_rdata[k];
            end
        end
    end

`ifdef N64_BANK_DISPATCHER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    // Count WAIT cycles; cleared when a valid request is accepted.
    always_comb begin
        count_d = count_q;
        if (state_q == ST_IDLE && i_request) begin
            count_d = '0;
        end else if (state_q == ST_WAIT) begin
            count_d = count_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_hit = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
    assign timeout_hit           = 1'b0;
`endif

    // Next-state and latch logic; an ack on the expiry cycle is a normal completion.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        bank_d    = bank_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        case (state_q)
            ST_IDLE: begin
                if (i_request) begin
                    write_d   = i_write;
                    bank_d    = i_bank;
                    address_d = i_address;
                    wdata_d   = i_wdata;
                    if (bank_valid) begin
                        error_d = 1'b0;
                        state_d = ST_WAIT;
                    end else begin
                        error_d = 1'b1;
                        rdata_d = 16'hFFFF;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (sel_ack) begin
                    rdata_d = write_q ? 16'h0000 : sel_rdata;
                    error_d = 1'b0;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    rdata_d = 16'hFFFF;
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-transaction registers; reset aborts any bank request at once.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            bank_q    <= 4'd0;
            address_q <= 26'd0;
            wdata_q   <= 16'd0;
            rdata_q   <= 16'd0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            bank_q    <= bank_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end

    assign o_busy         = (state_q != ST_IDLE);
    assign o_ack          = (state_q == ST_DONE);
    assign o_error        = (state_q == ST_DONE) && error_q;
    assign o_rdata        = rdata_q;
    assign o_bank_write   = write_q;
    assign o_bank_address = address_q;
    assign o_bank_wdata   = wdata_q;

endmodule

// File: tb/tb_n64_bank_dispatcher.sv
// Testbench for n64_bank_dispatcher: a scoreboard queue of expected completions
// is filled by the stimulus and drained by an independent o_ack monitor.
module tb_n64_bank_dispatcher;

    localparam int NB = 8;
    localparam int TO = 16;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_request;
    logic              i_write;
    logic [3:0]        i_bank;
    logic [25:0]       i_address;
    logic [15:0]       i_wdata;
    logic              o_busy;
    logic              o_ack;
    logic [15:0]       o_rdata;
    logic              o_error;
    logic [NB-1:0]     o_bank_request;
    logic              o_bank_write;
    logic [25:0]       o_bank_address;
    logic [15:0]       o_bank_wdata;
    logic [NB-1:0]     i_bank_ack;
    logic [16*NB-1:0]  i_bank_rdata;

    int tests = 0;
    int fails = 0;
    int acks_seen = 0;
    int pushed = 0;
    logic [16:0] exp_q [$];   // {error, rdata}
    logic [16:0] mon_e;

    n64_bank_dispatcher #(.NUM_BANKS(NB), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_request(i_request), .i_write(i_write),
        .i_bank(i_bank), .i_address(i_address), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_ack(o_ack), .o_rdata(o_rdata), .o_error(o_error),
        .o_bank_request(o_bank_request), .o_bank_write(o_bank_write),
        .o_bank_address(o_bank_address), .o_bank_wdata(o_bank_wdata),
        .i_bank_ack(i_bank_ack), .i_bank_rdata(i_bank_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every o_ack pops one expected completion from the scoreboard.
    always @(negedge i_clk) begin
        if (o_ack === 1'b1) begin
            acks_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got ack with rdata %h, expected no ack (t=%0t)", o_rdata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_rdata", 32'(o_rdata), 32'(mon_e[15:0]));
                chk("ack_error", 32'(o_error), 32'(mon_e[16]));
                chk("ack_busy", 32'(o_busy), 32'd1);
                $display("[TB] ack rdata=%h error=%0b", o_rdata, o_error);
            end
        end else if (o_error !== 1'b0) begin
            chk("error_without_ack", 32'(o_error), 32'd0);
        end
    end

    // One transaction: delay = WAIT cycle (1-based) in which the target acks.
    // noise adds spurious acks on other banks and extra requests while busy.
    task automatic txn(input logic w, input logic [3:0] b, input int delay, input bit noise);
        logic [15:0]   words [NB];
        logic [25:0]   a;
        logic [15:0]   wd;
        logic [16:0]   ex;
        logic [NB-1:0] oh;
        a  = 26'($urandom);
        wd = 16'($urandom);
        for (int k = 0; k < NB; k++) begin
            words[k] = 16'($urandom);
            i_bank_rdata[16*k +: 16] = words[k];
        end
        if (b >= 4'(NB)) ex = {1'b1, 16'hFFFF};
        else             ex = {1'b0, (w ? 16'h0000 : words[b[2:0]])};
        oh = NB'(1) << b;
        exp_q.push_back(ex);
        pushed++;
        $display("[TB] txn %s bank=%0d addr=%h wdata=%h delay=%0d noise=%0b",
                 w ? "WR" : "RD", b, a, wd, delay, noise);
        i_request = 1'b1; i_write = w; i_bank = b; i_address = a; i_wdata = wd;
        @(posedge i_clk); #1;
        i_request = 1'b0; i_write = ~w; i_bank = 4'($urandom); i_address = ~a; i_wdata = ~wd;
        if (b < 4'(NB)) begin
            for (int c = 1; c <= delay; c++) begin
                chk("bank_request", 32'(o_bank_request), 32'(oh));
                chk("busy_wait", 32'(o_busy), 32'd1);
                chk("bank_address", 32'(o_bank_address), 32'(a));
                chk("bank_write", 32'(o_bank_write), 32'(w));
                chk("bank_wdata", 32'(o_bank_wdata), 32'(wd));
                if (c == delay)  i_bank_ack = oh;
                else if (noise)  i_bank_ack = NB'($urandom) & ~oh;
                if (noise && c == 1) begin
                    i_request = 1'b1; i_bank = 4'($urandom_range(0, NB-1));
                end
                @(posedge i_clk); #1;
                i_bank_ack = '0;
                i_request  = 1'b0;
            end
        end else begin
            chk("invalid_no_request", 32'(o_bank_request), 32'd0);
        end
        chk("done_ack", 32'(o_ack), 32'd1);
        chk("done_no_request", 32'(o_bank_request), 32'd0);
        if (noise) begin
            i_request = 1'b1; i_bank = 4'($urandom_range(0, NB-1));
        end
        @(posedge i_clk); #1;
        i_request = 1'b0;
        chk("idle_after_done", 32'(o_busy), 32'd0);
        chk("rdata_hold", 32'(o_rdata), 32'(ex[15:0]));
        @(posedge i_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        i_reset = 1'b1; i_request = 1'b0; i_write = 1'b0; i_bank = 4'd0;
        i_address = '0; i_wdata = '0; i_bank_ack = '0; i_bank_rdata = '0;
        #12;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ack", 32'(o_ack), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        chk("rst_request", 32'(o_bank_request), 32'd0);
        chk("rst_address", 32'(o_bank_address), 32'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        // Directed cases, including bank-range boundaries and a 1-cycle bank.
        txn(1'b0, 4'd0, 3, 1'b0);
        txn(1'b1, 4'd3, 2, 1'b0);
        txn(1'b0, 4'hF, 0, 1'b0);
        txn(1'b0, 4'd2, 4, 1'b1);
        txn(1'b0, 4'd7, 1, 1'b0);
        txn(1'b1, 4'd8, 0, 1'b1);

        // Reset in the 2nd WAIT cycle aborts without an ack.
        $display("[TB] txn RD bank=2 aborted by reset");
        i_request = 1'b1; i_write = 1'b0; i_bank = 4'd2; i_address = 26'h0000100;
        @(posedge i_clk); #1;
        i_request = 1'b0;
        @(posedge i_clk); #1;
        chk("pre_reset_request", 32'(o_bank_request), 32'h04);
        i_reset = 1'b1;
        #1;
        chk("reset_drops_request", 32'(o_bank_request), 32'd0);
        chk("reset_drops_busy", 32'(o_busy), 32'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        txn(1'b0, 4'd2, 2, 1'b0);

`ifdef N64_BANK_DISPATCHER_TIMEOUT_EN
        // No ack: request must be held exactly TO cycles, then an error completion.
        exp_q.push_back({1'b1, 16'hFFFF});
        pushed++;
        $display("[TB] txn RD bank=1 timeout");
        i_request = 1'b1; i_write = 1'b0; i_bank = 4'd1;
        @(posedge i_clk); #1;
        i_request = 1'b0;
        cnt = 0;
        while (o_bank_request != '0 && cnt < 4*TO) begin
            cnt++;
            @(posedge i_clk); #1;
        end
        chk("timeout_cycles", 32'(cnt), 32'(TO));
        chk("timeout_ack", 32'(o_ack), 32'd1);
        @(posedge i_clk); #1;
`else
        cnt = 0;
`endif

        // Randomized traffic; bank range 0..11 includes invalid banks.
        for (int n = 0; n < 60; n++) begin
            txn(1'($urandom), 4'($urandom_range(0, 11)), int'($urandom_range(1, 6)), 1'($urandom));
        end

        repeat (3) @(posedge i_clk);
        #1;
        chk("acks_seen", 32'(acks_seen), 32'(pushed));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
